// File: rtl/sdram_wb_selftest.sv
// Power-up self-test initiator: writes a seeded pattern over a Wishbone B4 pipelined
// port, reads it back, and latches a sticky pass/fail plus the first failing word.
module sdram_wb_selftest #(
  parameter int unsigned       ADDR_W    = 25,
  parameter int unsigned       NUM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       SEED      = 32'hA5A5_0001,
  parameter int unsigned       TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [3:0]        wb_sel,
  output logic [31:0]       wb_wdata,
  input  logic [31:0]       wb_rdata,
  input  logic              wb_ack,
  input  logic              wb_stall,
  output logic              pass_led,
  output logic              fail_led,
  output logic              busy,
  output logic [ADDR_W-1:0] err_addr,
  output logic [31:0]       err_data
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [16:0]   LAST     = 17'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_GAP, S_RD_REQ, S_RD_WAIT, S_PASS, S_FAIL
  } state_t;

  state_t        state;
  logic [16:0]   idx;
  logic [16:0]   nxt;
  logic [TW-1:0] tmo;

  assign nxt = idx + 17'd1;

  function automatic logic [31:0] pattern(input logic [15:0] i);
    return SEED ^ {~i, i};
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [16:0] i);
    return BASE_ADDR + ADDR_W'(i);
  endfunction

  // The timeout counter spans request and ack of one word; it is only
  // cleared when the next request is issued, hence the >= compare in *_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      tmo      <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_sel   <= '0;
      wb_wdata <= '0;
      pass_led <= 1'b0;
      fail_led <= 1'b0;
      busy     <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ready) begin
            state    <= S_WR_REQ;
            idx      <= '0;
            tmo      <= '0;
            busy     <= 1'b1;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_we    <= 1'b1;
            wb_sel   <= '1;
            wb_addr  <= addr_of('0);
            wb_wdata <= pattern('0);
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          if (!wb_stall) begin
            state  <= (state == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
            wb_stb <= 1'b0;
            wb_sel <= '0;
            tmo    <= tmo + TW'(1);
          end else if (tmo >= TMO_LAST) begin
            state    <= S_FAIL;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_sel   <= '0;
            busy     <= 1'b0;
            fail_led <= 1'b1;
            err_addr <= wb_addr;
            err_data <= '0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_WR_WAIT: begin
          if (wb_ack) begin
            if (idx == LAST) begin
              state  <= S_GAP;
              idx    <= '0;
              wb_cyc <= 1'b0;
              wb_we  <= 1'b0;
            end else begin
              state    <= S_WR_REQ;
              idx      <= nxt;
              tmo      <= '0;
              wb_stb   <= 1'b1;
              wb_sel   <= '1;
              wb_addr  <= addr_of(nxt);
              wb_wdata <= pattern(nxt[15:0]);
            end
          end else if (tmo >= TMO_LAST) begin
            state    <= S_FAIL;
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            busy     <= 1'b0;
            fail_led <= 1'b1;
            err_addr <= wb_addr;
            err_data <= '0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_GAP: begin
          state    <= S_RD_REQ;
          tmo      <= '0;
          wb_cyc   <= 1'b1;
          wb_stb   <= 1'b1;
          wb_sel   <= '1;
          wb_addr  <= addr_of('0);
          wb_wdata <= '0;
        end
        S_RD_WAIT: begin
          if (wb_ack) begin
            if (wb_rdata != pattern(idx[15:0])) begin
              state    <= S_FAIL;
              wb_cyc   <= 1'b0;
              busy     <= 1'b0;
              fail_led <= 1'b1;
              err_addr <= wb_addr;
              err_data <= wb_rdata;
            end else if (idx == LAST) begin
              state    <= S_PASS;
              wb_cyc   <= 1'b0;
              busy     <= 1'b0;
              pass_led <= 1'b1;
            end else begin
              state   <= S_RD_REQ;
              idx     <= nxt;
              tmo     <= '0;
              wb_stb  <= 1'b1;
              wb_sel  <= '1;
              wb_addr <= addr_of(nxt);
            end
          end else if (tmo >= TMO_LAST) begin
            state    <= S_FAIL;
            wb_cyc   <= 1'b0;
            busy     <= 1'b0;
            fail_led <= 1'b1;
            err_addr <= wb_addr;
            err_data <= '0;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
